// File: rtl/corr_pkg.sv
// Shared types and constants for the correlator sequencer and its peak search.
// Pure declarations, no latency; no flow control.
`timescale 1ns/1ps
package corr_pkg;
    localparam int N_SAMPLES = 4;
    localparam int N_LAGS    = 7;
    localparam int SAMPLE_W  = 10;

    localparam logic [2:0] CORR_IDLE = 3'b000;
    localparam logic [2:0] CORR_RUN  = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        RUN,
        SCAN,
        HOLD,
        ERR
    } state_t;

    typedef logic [SAMPLE_W-1:0]                 sample_t;
    typedef logic [N_SAMPLES-1:0][SAMPLE_W-1:0]  buf_t;
    typedef logic [N_LAGS-1:0][SAMPLE_W-1:0]     lags_t;
endpackage

// File: rtl/peak_scan.sv
// Running unsigned maximum and its lag index, one candidate per step.
// Result registered one cycle after each step; no backpressure (caller paces steps).
`timescale 1ns/1ps
module peak_scan
    import corr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        step_i,
    input  sample_t     val_i,
    input  logic [2:0]  lag_i,
    output sample_t     peak_val_o,
    output logic [2:0]  peak_lag_o
);
    sample_t    max_q;
    logic [2:0] lag_q;

    // Strict greater-than keeps the lowest lag on ties; a zero start value
    // leaves lag 0 selected when every candidate is zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_q <= '0;
            lag_q <= '0;
        end else if (clear_i) begin
            max_q <= '0;
            lag_q <= '0;
        end else if (step_i && (val_i > max_q)) begin
            max_q <= val_i;
            lag_q <= lag_i;
        end
    end

    assign peak_val_o = max_q;
    assign peak_lag_o = lag_q;
endmodule

// File: rtl/corr_sequencer.sv
// Loads two 4-sample buffers, runs the correlator, then scans 7 lag results for the peak.
// Peak valid RUN+7+1 cycles after the last load; sample_ready gates loads, HOLD waits for res_ack.
`timescale 1ns/1ps
module corr_sequencer
    import corr_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [SAMPLE_W-1:0]                sample_in,
    input  logic                               sample_valid,
    output logic                               sample_ready,
    input  logic                               abort,
    output logic [2:0]                         corr_state,
    output logic [N_SAMPLES-1:0][SAMPLE_W-1:0] corr_a,
    output logic [N_SAMPLES-1:0][SAMPLE_W-1:0] corr_b,
    input  logic [N_LAGS-1:0][SAMPLE_W-1:0]    corr_result,
    input  logic                               corr_finished,
    output logic [SAMPLE_W-1:0]                peak_val,
    output logic [2:0]                         peak_lag,
    output logic                               res_valid,
    input  logic                               res_ack,
    output logic                               error
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state_q, state_d;
    logic [1:0]       load_idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [2:0]       scan_idx_q;
    buf_t             a_q, b_q;
    lags_t            res_q;
    logic             sample_ready_q, res_valid_q, error_q;
    logic [2:0]       corr_state_q;
    logic             xfer;

    assign xfer    = sample_valid & sample_ready_q;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   state_d = LOAD_A;
            LOAD_A: if (xfer && load_idx_q == 2'(N_SAMPLES-1)) state_d = LOAD_B;
            LOAD_B: if (xfer && load_idx_q == 2'(N_SAMPLES-1)) state_d = RUN;
            RUN: begin
                if (corr_finished)                              state_d = SCAN;
                else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES))     state_d = ERR;
            end
            SCAN:   if (scan_idx_q == 3'(N_LAGS-1)) state_d = HOLD;
            HOLD:   if (res_ack) state_d = IDLE;
            ERR:    state_d = ERR;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Outputs are registered from the next state so they change with the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            corr_state_q   <= CORR_IDLE;
            sample_ready_q <= 1'b0;
            res_valid_q    <= 1'b0;
            error_q        <= 1'b0;
            load_idx_q     <= '0;
            cnt_q          <= '0;
            scan_idx_q     <= '0;
            a_q            <= '0;
            b_q            <= '0;
            res_q          <= '0;
        end else begin
            state_q        <= state_d;
            corr_state_q   <= (state_d == RUN) ? CORR_RUN : CORR_IDLE;
            sample_ready_q <= (state_d == LOAD_A) || (state_d == LOAD_B);
            res_valid_q    <= (state_d == HOLD);
            error_q        <= (state_d == ERR);
            case (state_q)
                IDLE: begin
                    load_idx_q <= '0;
                    cnt_q      <= '0;
                    scan_idx_q <= '0;
                    a_q        <= '0;
                    b_q        <= '0;
                    res_q      <= '0;
                end
                LOAD_A: if (xfer) begin
                    a_q[load_idx_q] <= sample_in;
                    load_idx_q      <= load_idx_q + 2'd1;
                end
                LOAD_B: if (xfer) begin
                    b_q[load_idx_q] <= sample_in;
                    load_idx_q      <= load_idx_q + 2'd1;
                end
                RUN: begin
                    cnt_q <= cnt_inc;
                    if (corr_finished) res_q <= corr_result;
                end
                SCAN: scan_idx_q <= scan_idx_q + 3'd1;
                default: ;
            endcase
        end
    end

    peak_scan u_peak_scan (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (state_q == IDLE),
        .step_i     (state_q == SCAN),
        .val_i      (res_q[scan_idx_q]),
        .lag_i      (scan_idx_q),
        .peak_val_o (peak_val),
        .peak_lag_o (peak_lag)
    );

    assign sample_ready = sample_ready_q;
    assign corr_state   = corr_state_q;
    assign corr_a       = a_q;
    assign corr_b       = b_q;
    assign res_valid    = res_valid_q;
    assign error        = error_q;
endmodule

// File: doc/corr_sequencer.md
CORR_SEQUENCER -- requirements
Module: corr_sequencer

Interface
REQ-001 The block SHALL use one clock, clk, and one reset, reset; reset is asynchronous and active-high.
REQ-002 Parameter TIMEOUT_CYCLES, default 63: the maximum number of RUN cycles allowed before an error is flagged.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  async active-high reset.
REQ-005 sample_in  input  10  unsigned sample word.
REQ-006 sample_valid  input  1  sample_in is valid this cycle.
REQ-007 sample_ready  output  1  block accepts a sample this cycle.
REQ-008 abort  input  1  synchronous return to IDLE.
REQ-009 corr_state  output  3  mode code to the correlator.
REQ-010 corr_a, corr_b  output  4x10 each  sample buffers, held stable while corr_state is RUN.
REQ-011 corr_result  input  7x10  correlator lag outputs.
REQ-012 corr_finished  input  1  correlator done flag.
REQ-013 peak_val  output  10  maximum lag value.
REQ-014 peak_lag  output  3  index of that maximum.
REQ-015 res_valid  output  1  peak outputs are valid.
REQ-016 res_ack  input  1  consumer accepts the result.
REQ-017 error  output  1  timeout occurred; sticky until abort or reset.

Function
REQ-018 The state machine SHALL have these states: IDLE, LOAD_A, LOAD_B, RUN, SCAN, HOLD, ERR.
REQ-019 IDLE SHALL move to LOAD_A unconditionally on the next cycle, and SHALL clear the load index, timeout counter and scan registers.
REQ-020 In LOAD_A and LOAD_B, sample_ready SHALL be 1, and a transfer SHALL occur on sample_valid&sample_ready.
- The 2-bit load index selects the buffer entry.
- LOAD_A moves to LOAD_B after transfer index 3.
- LOAD_B moves to RUN after transfer index 3.
- The first accepted sample goes to entry 0.
REQ-021 sample_ready SHALL be 0 in every state except LOAD_A and LOAD_B.
REQ-022 corr_state SHALL be 3'b010 in RUN only, and 3'b000 in all other states, so the correlator clears itself.
REQ-023 In RUN, the timeout counter SHALL increment each cycle.
- corr_finished=1 moves to SCAN.
- Otherwise, counter==TIMEOUT_CYCLES moves to ERR.
- If both occur in the same cycle, SCAN wins.
REQ-024 On entry to SCAN, corr_result SHALL be captured into a 7-entry register.
REQ-025 SCAN SHALL examine one entry per cycle, lags 0..6, for 7 cycles.
- The comparison is unsigned.
- Replacement uses strict greater-than, so on a tie the lowest lag wins.
REQ-026 After lag 6 is examined, SCAN SHALL move to HOLD.
REQ-027 In HOLD, res_valid SHALL be 1 and peak_val and peak_lag SHALL be stable.
- res_ack=1 moves to IDLE.
- res_valid falls on the following cycle.
REQ-028 ERR SHALL drive error=1 and res_valid=0, and SHALL remain in ERR until abort or reset.
REQ-029 abort=1 in any state SHALL move to IDLE on the next edge.
- All partial loads are discarded.
- error is cleared.
- abort has priority over every other transition, including a simultaneous res_ack or corr_finished.
REQ-030 Latency from the last LOAD_B transfer to res_valid SHALL be (RUN cycles)+7+1 cycles.
REQ-031 The all-zero result SHALL give peak_val=0, peak_lag=0.

Reset
REQ-032 Asserting reset SHALL force the following values immediately, independent of clk:
- state=IDLE, corr_state=3'b000, sample_ready=0
- corr_a, corr_b = all zero
- peak_val=0, peak_lag=0, res_valid=0, error=0
- load index and timeout counter = 0
REQ-033 Reset asserted mid-load or mid-RUN SHALL leave no residual buffer contents after release.

Structure
REQ-034 Shared package corr_pkg SHALL hold:
- the state typedef;
- the mode codes CORR_IDLE=3'b000 and CORR_RUN=3'b010;
- the constants N_SAMPLES=4, N_LAGS=7, SAMPLE_W=10.
REQ-035 Peak search SHALL be a sub-module, peak_scan, holding the running max and index, with a clear and a step input.

Verification
REQ-036 Normal run: load a={1,2,3,4}, b={4,3,2,1}; the stub returns {3,7,2,5,1,0,0} after 10 RUN cycles -> peak_val=7, peak_lag=1, res_valid 18 cycles after the last load.
REQ-037 Tie: stub result {2,9,9,1,0,0,9} -> peak_lag=1, peak_val=9.
REQ-038 Timeout: the stub never asserts finished -> after TIMEOUT_CYCLES RUN cycles, error=1, corr_state=0, and error persists until abort.
REQ-039 Back-pressure: sample_valid toggles every other cycle -> exactly 8 samples are captured in order, and no sample is taken outside LOAD states.
REQ-040 Abort mid-LOAD_B after 2 samples -> IDLE next cycle, and a fresh 8-sample load yields correct buffers.
REQ-041 Async reset asserted between clock edges during HOLD -> res_valid, peak_val and peak_lag drop to 0 before the next edge.
